// File: rtl/alu_share_arbiter_if.sv
// Request/response handshake bundle for the two ALU requesters of alu_share_arbiter.
// The requester side uses the master modport and the arbiter uses the slave modport.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CTL_W   = 3,
  parameter int unsigned SHAMT_W = 5
);
  logic               req_valid0, req_valid1;
  logic               req_ready0, req_ready1;
  logic [CTL_W-1:0]   req_ctl0, req_ctl1;
  logic [DATA_W-1:0]  req_a0, req_a1;
  logic [DATA_W-1:0]  req_b0, req_b1;
  logic [SHAMT_W-1:0] req_shamt0, req_shamt1;
  logic               rsp_valid0, rsp_valid1;
  logic               rsp_ready0, rsp_ready1;
  logic [DATA_W-1:0]  rsp_data0, rsp_data1;

  modport master (
    output req_valid0, req_valid1, req_ctl0, req_ctl1, req_a0, req_a1,
           req_b0, req_b1, req_shamt0, req_shamt1, rsp_ready0, rsp_ready1,
    input  req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_data0, rsp_data1
  );

  modport slave (
    input  req_valid0, req_valid1, req_ctl0, req_ctl1, req_a0, req_a1,
           req_b0, req_b1, req_shamt0, req_shamt1, rsp_ready0, rsp_ready1,
    output req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_data0, rsp_data1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// registered per-port response. Optional grant/conflict counters: ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      CTL_W    = 3,
  parameter int unsigned      SHAMT_W  = 5,
  parameter logic [CTL_W-1:0] IDLE_CTL = 3'b010
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus,
  output logic [CTL_W-1:0]   alu_ctl,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               grant_port
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]        stat_grant0,
  output logic [15:0]        stat_grant1,
  output logic [15:0]        stat_conflict
`endif
);

  localparam int unsigned STAT_W = 16;

  logic              rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
  logic [DATA_W-1:0] rsp_data0_q, rsp_data0_d, rsp_data1_q, rsp_data1_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_port_q, grant_port_d;
  logic              elig0, elig1, grant0, grant1, conflict;

  // A port may only be granted if its response slot is free or being drained.
  always_comb begin
    elig0    = ~rst & bus.req_valid0 & (~rsp_valid0_q | bus.rsp_ready0);
    elig1    = ~rst & bus.req_valid1 & (~rsp_valid1_q | bus.rsp_ready1);
    conflict = elig0 & elig1;
    grant0   = elig0 & (~elig1 | last_grant_q);
    grant1   = elig1 & (~elig0 | ~last_grant_q);
  end

  always_comb begin
    alu_ctl   = IDLE_CTL;
    alu_a     = '0;
    alu_b     = '0;
    alu_shamt = '0;
    if (grant0) begin
      alu_ctl   = bus.req_ctl0;
      alu_a     = bus.req_a0;
      alu_b     = bus.req_b0;
      alu_shamt = bus.req_shamt0;
    end else if (grant1) begin
      alu_ctl   = bus.req_ctl1;
      alu_a     = bus.req_a1;
      alu_b     = bus.req_b1;
      alu_shamt = bus.req_shamt1;
    end
  end

  // A consume and a new grant in the same cycle keep the slot valid with new data.
  always_comb begin
    rsp_valid0_d = rsp_valid0_q & ~bus.rsp_ready0;
    rsp_valid1_d = rsp_valid1_q & ~bus.rsp_ready1;
    rsp_data0_d  = rsp_data0_q;
    rsp_data1_d  = rsp_data1_q;
    last_grant_d = last_grant_q;
    grant_port_d = grant_port_q;
    if (grant0) begin
      rsp_valid0_d = 1'b1;
      rsp_data0_d  = alu_result;
      last_grant_d = 1'b0;
      grant_port_d = 1'b0;
    end
    if (grant1) begin
      rsp_valid1_d = 1'b1;
      rsp_data1_d  = alu_result;
      last_grant_d = 1'b1;
      grant_port_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_data0_q  <= '0;
      rsp_data1_q  <= '0;
      last_grant_q <= 1'b1;
      grant_port_q <= 1'b1;
    end else begin
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_data0_q  <= rsp_data0_d;
      rsp_data1_q  <= rsp_data1_d;
      last_grant_q <= last_grant_d;
      grant_port_q <= grant_port_d;
    end
  end

  assign bus.req_ready0 = grant0;
  assign bus.req_ready1 = grant1;
  assign bus.rsp_valid0 = rsp_valid0_q;
  assign bus.rsp_valid1 = rsp_valid1_q;
  assign bus.rsp_data0  = rsp_data0_q;
  assign bus.rsp_data1  = rsp_data1_q;
  assign grant_port     = grant_port_q;

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] stat_grant0_q, stat_grant0_d;
  logic [STAT_W-1:0] stat_grant1_q, stat_grant1_d;
  logic [STAT_W-1:0] stat_conflict_q, stat_conflict_d;

  // Saturating event counters.
  always_comb begin
    stat_grant0_d   = stat_grant0_q;
    stat_grant1_d   = stat_grant1_q;
    stat_conflict_d = stat_conflict_q;
    if (grant0 && (stat_grant0_q != '1))     stat_grant0_d   = stat_grant0_q + STAT_W'(1);
    if (grant1 && (stat_grant1_q != '1))     stat_grant1_d   = stat_grant1_q + STAT_W'(1);
    if (conflict && (stat_conflict_q != '1)) stat_conflict_d = stat_conflict_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0_q   <= '0;
      stat_grant1_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_grant0_q   <= stat_grant0_d;
      stat_grant1_q   <= stat_grant1_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_grant0   = stat_grant0_q;
  assign stat_grant1   = stat_grant1_q;
  assign stat_conflict = stat_conflict_q;
`else
  logic unused_stats;
  assign unused_stats = conflict & (STAT_W != 0);
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed table-driven bench for alu_share_arbiter with a behavioural ALU model;
// stats checks are compiled in when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                         OP_SLL = 3'b011, OP_SUB = 3'b110, OP_SLT = 3'b111;
  localparam logic [31:0] Z = 32'd0;
  localparam logic [4:0]  S0 = 5'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic        grant_port;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  int tests = 0;
  int fails = 0;

  alu_share_arbiter_if #(.DATA_W(32), .CTL_W(3), .SHAMT_W(5)) bus ();

  alu_share_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_shamt  (alu_shamt),
    .alu_result (alu_result),
    .grant_port (grant_port)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // External ALU model.
  always_comb begin
    case (alu_ctl)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SLL:  alu_result = alu_b << alu_shamt;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_SLT:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = 32'd0;
    endcase
  end

  typedef struct {
    logic v0; logic [2:0] c0; logic [31:0] a0; logic [31:0] b0; logic [4:0] s0; logic rr0;
    logic v1; logic [2:0] c1; logic [31:0] a1; logic [31:0] b1; logic [4:0] s1; logic rr1;
    logic ry0; logic ry1; logic [2:0] actl; logic [31:0] aa; logic [31:0] ab; logic [4:0] ash;
    logic rv0; logic [31:0] rd0; logic rv1; logic [31:0] rd1; logic gp;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t r);
    bus.req_valid0 = r.v0; bus.req_ctl0 = r.c0; bus.req_a0 = r.a0;
    bus.req_b0 = r.b0; bus.req_shamt0 = r.s0; bus.rsp_ready0 = r.rr0;
    bus.req_valid1 = r.v1; bus.req_ctl1 = r.c1; bus.req_a1 = r.a1;
    bus.req_b1 = r.b1; bus.req_shamt1 = r.s1; bus.rsp_ready1 = r.rr1;
  endtask

  task automatic idle_inputs();
    vec_t r;
    r = '{1'b0, OP_ADD, Z, Z, S0, 1'b1, 1'b0, OP_ADD, Z, Z, S0, 1'b1,
          1'b0, 1'b0, OP_ADD, Z, Z, S0, 1'b0, Z, 1'b0, Z, 1'b1};
    drive(r);
  endtask

  initial begin
    // Row order: port0 inputs, port1 inputs, same-cycle expects, post-edge expects.
    vec[0]  = '{1'b0, OP_ADD, Z, Z, S0, 1'b0,  1'b0, OP_ADD, Z, Z, S0, 1'b0,
                1'b0, 1'b0, OP_ADD, Z, Z, S0,  1'b0, Z, 1'b0, Z, 1'b1};
    vec[1]  = '{1'b1, OP_ADD, 32'd5, 32'd3, S0, 1'b0,  1'b0, OP_ADD, Z, Z, S0, 1'b0,
                1'b1, 1'b0, OP_ADD, 32'd5, 32'd3, S0,  1'b1, 32'd8, 1'b0, Z, 1'b0};
    vec[2]  = '{1'b0, OP_ADD, Z, Z, S0, 1'b1,  1'b0, OP_ADD, Z, Z, S0, 1'b0,
                1'b0, 1'b0, OP_ADD, Z, Z, S0,  1'b0, 32'd8, 1'b0, Z, 1'b0};
    vec[3]  = '{1'b1, OP_SUB, 32'd10, 32'd4, S0, 1'b1,  1'b1, OP_SLT, 32'd2, 32'd7, S0, 1'b1,
                1'b0, 1'b1, OP_SLT, 32'd2, 32'd7, S0,  1'b0, 32'd8, 1'b1, 32'd1, 1'b1};
    vec[4]  = '{1'b1, OP_SUB, 32'd10, 32'd4, S0, 1'b1,  1'b1, OP_SLT, 32'd2, 32'd7, S0, 1'b1,
                1'b1, 1'b0, OP_SUB, 32'd10, 32'd4, S0,  1'b1, 32'd6, 1'b0, 32'd1, 1'b0};
    vec[5]  = '{1'b1, OP_SUB, 32'd10, 32'd4, S0, 1'b1,  1'b1, OP_SLT, 32'd2, 32'd7, S0, 1'b1,
                1'b0, 1'b1, OP_SLT, 32'd2, 32'd7, S0,  1'b0, 32'd6, 1'b1, 32'd1, 1'b1};
    vec[6]  = '{1'b1, OP_SUB, 32'd10, 32'd4, S0, 1'b1,  1'b1, OP_SLT, 32'd2, 32'd7, S0, 1'b1,
                1'b1, 1'b0, OP_SUB, 32'd10, 32'd4, S0,  1'b1, 32'd6, 1'b0, 32'd1, 1'b0};
    vec[7]  = '{1'b0, OP_ADD, Z, Z, S0, 1'b1,  1'b1, OP_SLL, Z, 32'd1, 5'd4, 1'b0,
                1'b0, 1'b1, OP_SLL, Z, 32'd1, 5'd4,  1'b0, 32'd6, 1'b1, 32'd16, 1'b1};
    vec[8]  = '{1'b1, OP_OR, 32'hF0, 32'h0F, S0, 1'b0,  1'b1, OP_SLL, Z, 32'd1, 5'd4, 1'b0,
                1'b1, 1'b0, OP_OR, 32'hF0, 32'h0F, S0,  1'b1, 32'hFF, 1'b1, 32'd16, 1'b0};
    vec[9]  = '{1'b1, OP_OR, 32'hF0, 32'h0F, S0, 1'b1,  1'b1, OP_SLL, Z, 32'd1, 5'd4, 1'b0,
                1'b1, 1'b0, OP_OR, 32'hF0, 32'h0F, S0,  1'b1, 32'hFF, 1'b1, 32'd16, 1'b0};
    vec[10] = vec[9];
    vec[11] = '{1'b1, OP_AND, 32'hFF, 32'h0F, S0, 1'b1,  1'b0, OP_ADD, Z, Z, S0, 1'b1,
                1'b1, 1'b0, OP_AND, 32'hFF, 32'h0F, S0,  1'b1, 32'h0F, 1'b0, 32'd16, 1'b0};
    vec[12] = '{1'b1, OP_ADD, 32'd1, 32'd1, S0, 1'b1,  1'b0, OP_ADD, Z, Z, S0, 1'b1,
                1'b1, 1'b0, OP_ADD, 32'd1, 32'd1, S0,  1'b1, 32'd2, 1'b0, 32'd16, 1'b0};
    vec[13] = '{1'b0, OP_ADD, Z, Z, S0, 1'b0,  1'b0, OP_ADD, Z, Z, S0, 1'b1,
                1'b0, 1'b0, OP_ADD, Z, Z, S0,  1'b1, 32'd2, 1'b0, 32'd16, 1'b0};
    vec[14] = '{1'b0, OP_ADD, Z, Z, S0, 1'b1,  1'b0, OP_ADD, Z, Z, S0, 1'b1,
                1'b0, 1'b0, OP_ADD, Z, Z, S0,  1'b0, 32'd2, 1'b0, 32'd16, 1'b0};

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("reset rsp_valid0", 32'(bus.rsp_valid0), 32'd0);
    chk("reset rsp_valid1", 32'(bus.rsp_valid1), 32'd0);
    chk("reset rsp_data0", bus.rsp_data0, Z);
    chk("reset rsp_data1", bus.rsp_data1, Z);
    chk("reset grant_port", 32'(grant_port), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vec[i]);
      #1;
      chk($sformatf("v%0d req_ready0", i), 32'(bus.req_ready0), 32'(vec[i].ry0));
      chk($sformatf("v%0d req_ready1", i), 32'(bus.req_ready1), 32'(vec[i].ry1));
      chk($sformatf("v%0d alu_ctl", i), 32'(alu_ctl), 32'(vec[i].actl));
      chk($sformatf("v%0d alu_a", i), alu_a, vec[i].aa);
      chk($sformatf("v%0d alu_b", i), alu_b, vec[i].ab);
      chk($sformatf("v%0d alu_shamt", i), 32'(alu_shamt), 32'(vec[i].ash));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid0", i), 32'(bus.rsp_valid0), 32'(vec[i].rv0));
      chk($sformatf("v%0d rsp_data0", i), bus.rsp_data0, vec[i].rd0);
      chk($sformatf("v%0d rsp_valid1", i), 32'(bus.rsp_valid1), 32'(vec[i].rv1));
      chk($sformatf("v%0d rsp_data1", i), bus.rsp_data1, vec[i].rd1);
      chk($sformatf("v%0d grant_port", i), 32'(grant_port), 32'(vec[i].gp));
      @(negedge clk);
    end

`ifdef ALU_ARB_STATS_EN
    chk("stat_grant0 table", 32'(stat_grant0), 32'd8);
    chk("stat_grant1 table", 32'(stat_grant1), 32'd3);
    chk("stat_conflict table", 32'(stat_conflict), 32'd4);
`endif

    // Build two held responses: port 1 wins the tie, port 0 follows.
    bus.req_valid0 = 1'b1; bus.req_ctl0 = OP_ADD; bus.req_a0 = 32'd5; bus.req_b0 = 32'd3;
    bus.req_shamt0 = S0; bus.rsp_ready0 = 1'b0;
    bus.req_valid1 = 1'b1; bus.req_ctl1 = OP_SLL; bus.req_a1 = Z; bus.req_b1 = 32'd1;
    bus.req_shamt1 = 5'd4; bus.rsp_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("pending rsp_valid0", 32'(bus.rsp_valid0), 32'd1);
    chk("pending rsp_valid1", 32'(bus.rsp_valid1), 32'd1);
    chk("pending rsp_data0", bus.rsp_data0, 32'd8);
    chk("pending rsp_data1", bus.rsp_data1, 32'd16);

    // Mid-cycle asynchronous reset with both responses pending.
    #1;
    rst = 1'b1;
    bus.rsp_ready0 = 1'b1; bus.rsp_ready1 = 1'b1;
    #1;
    chk("async rst rsp_valid0", 32'(bus.rsp_valid0), 32'd0);
    chk("async rst rsp_valid1", 32'(bus.rsp_valid1), 32'd0);
    chk("async rst rsp_data0", bus.rsp_data0, Z);
    chk("async rst grant_port", 32'(grant_port), 32'd1);
    chk("rst req_ready0", 32'(bus.req_ready0), 32'd0);
    chk("rst req_ready1", 32'(bus.req_ready1), 32'd0);
    chk("rst alu_ctl idle", 32'(alu_ctl), 32'(OP_ADD));
    @(posedge clk);
    #1;
    chk("rst edge no capture", 32'(bus.rsp_valid0), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rst stat_grant0", 32'(stat_grant0), 32'd0);
    chk("rst stat_conflict", 32'(stat_conflict), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst req_ready0", 32'(bus.req_ready0), 32'd1);
    chk("post-rst req_ready1", 32'(bus.req_ready1), 32'd0);
    @(posedge clk);
    #1;
    chk("post-rst rsp_data0", bus.rsp_data0, 32'd8);
    chk("post-rst grant_port", 32'(grant_port), 32'd0);
    @(negedge clk);
    idle_inputs();

`ifdef ALU_ARB_STATS_EN
    // Saturation: port 0 alone, back to back, past the counter limit.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid0 = 1'b1; bus.req_ctl0 = OP_ADD; bus.req_a0 = 32'd1; bus.req_b0 = 32'd1;
    repeat (65540) @(negedge clk);
    #1;
    chk("stat_grant0 saturated", 32'(stat_grant0), 32'h0000FFFF);
    chk("stat_grant1 zero", 32'(stat_grant1), 32'd0);
    idle_inputs();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
